// File: rtl/fp_div_seq.sv
// Sequential FP32 divider: restoring division, one quotient bit per clock, fixed 28-cycle latency.
// Define FP_DIV_FLAGS_EN to add the registered {invalid, div_by_zero, overflow, underflow, inexact} port.
module fp_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
`ifdef FP_DIV_FLAGS_EN
    ,
    output logic [4:0]  flags
`endif
);

    typedef enum logic [1:0] {IDLE, UNPACK, DIVIDE, ROUND} state_t;

    state_t state, state_n;
    logic [4:0] cnt;

    logic [31:0]        a_q, b_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [25:0]        rem_q;
    logic [23:0]        mb_q;
    logic [25:0]        quo_q;
    logic               spec_q;
    logic [31:0]        spec_res_q;

    logic               spec;
    logic [31:0]        spec_res;
    logic               rem_ge;
    logic [24:0]        rem_diff;
    logic [32:0]        rnd;
    logic signed [9:0]  rnd_e;
    logic [31:0]        res_n;

    // Normalise the 26-bit quotient, round to nearest even; returns {exponent, fraction}.
    function automatic logic [32:0] rne_round(input logic [25:0] q, input logic st,
                                               input logic signed [9:0] e_in);
        logic [23:0]       m;
        logic              g;
        logic              s;
        logic signed [9:0] e;
        logic [24:0]       mr;
        if (q[25]) begin
            m = q[25:2];
            g = q[1];
            s = q[0] | st;
            e = e_in;
        end else begin
            m = q[24:1];
            g = q[0];
            s = st;
            e = e_in - 10'sd1;
        end
        mr = {1'b0, m} + {24'd0, g & (s | m[0])};
        if (mr[24])
            return {e + 10'sd1, mr[23:1]};
        return {e, mr[22:0]};
    endfunction

    // Leading-one position of an (a/b) mantissa quotient in [0.5, 2) is q[25] or q[24].
    wire a_zero = (a_q[30:23] == 8'd0);
    wire b_zero = (b_q[30:23] == 8'd0);
    wire a_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
    wire b_inf  = (&b_q[30:23]) & ~(|b_q[22:0]);
    wire a_nan  = (&a_q[30:23]) & (|a_q[22:0]);
    wire b_nan  = (&b_q[30:23]) & (|b_q[22:0]);
    wire sign_u = a_q[31] ^ b_q[31];

`ifdef FP_DIV_FLAGS_EN
    logic [4:0] spec_fl, spec_fl_q, flags_n;

    function automatic logic round_inexact(input logic [25:0] q, input logic st);
        return q[25] ? (q[1] | q[0] | st) : (q[0] | st);
    endfunction
`endif

    always_comb begin
        spec     = 1'b1;
        spec_res = 32'h7FC00000;
`ifdef FP_DIV_FLAGS_EN
        spec_fl  = 5'b00000;
`endif
        if (a_nan | b_nan) begin
            spec_res = 32'h7FC00000;
        end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
`ifdef FP_DIV_FLAGS_EN
            spec_fl  = 5'b10000;
`endif
        end else if (a_inf) begin
            spec_res = {sign_u, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_res = {sign_u, 8'hFF, 23'd0};
`ifdef FP_DIV_FLAGS_EN
            spec_fl  = 5'b01000;
`endif
        end else if (a_zero | b_inf) begin
            spec_res = {sign_u, 31'd0};
        end else begin
            spec = 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = UNPACK;
            UNPACK:  state_n = DIVIDE;
            DIVIDE:  if (cnt == 5'd0) state_n = ROUND;
            ROUND:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign rem_ge   = (rem_q >= {2'b00, mb_q});
    assign rem_diff = rem_q[24:0] - {1'b0, mb_q};
    assign rnd      = rne_round(quo_q, |rem_q, exp_q);
    assign rnd_e    = $signed(rnd[32:23]);

    always_comb begin
        if (spec_q)
            res_n = spec_res_q;
        else if (rnd_e >= 10'sd255)
            res_n = {sign_q, 8'hFF, 23'd0};
        else if (rnd_e <= 10'sd0)
            res_n = {sign_q, 31'd0};
        else
            res_n = {sign_q, rnd_e[7:0], rnd[22:0]};
    end

`ifdef FP_DIV_FLAGS_EN
    always_comb begin
        if (spec_q)
            flags_n = spec_fl_q;
        else if (rnd_e >= 10'sd255)
            flags_n = 5'b00101;
        else if (rnd_e <= 10'sd0)
            flags_n = 5'b00011;
        else
            flags_n = {4'b0000, round_inexact(quo_q, |rem_q)};
    end
`endif

    // Control path: state, counter and the registered result/handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
            done  <= 1'b0;
            out   <= 32'h0;
`ifdef FP_DIV_FLAGS_EN
            flags <= 5'b0;
`endif
        end else begin
            state <= state_n;
            done  <= 1'b0;
            case (state)
                UNPACK: cnt <= 5'd25;
                DIVIDE: if (cnt != 5'd0) cnt <= cnt - 5'd1;
                ROUND: begin
                    done  <= 1'b1;
                    out   <= res_n;
`ifdef FP_DIV_FLAGS_EN
                    flags <= flags_n;
`endif
                end
                default: ;
            endcase
        end
    end

    // Datapath: operand latch, unpack, and one restoring step per DIVIDE cycle.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    a_q <= dividend;
                    b_q <= divisor;
                end
            end
            UNPACK: begin
                sign_q     <= sign_u;
                exp_q      <= $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
                rem_q      <= {3'b001, a_q[22:0]};
                mb_q       <= {1'b1, b_q[22:0]};
                quo_q      <= 26'd0;
                spec_q     <= spec;
                spec_res_q <= spec_res;
`ifdef FP_DIV_FLAGS_EN
                spec_fl_q  <= spec_fl;
`endif
            end
            DIVIDE: begin
                rem_q <= rem_ge ? {rem_diff, 1'b0} : {rem_q[24:0], 1'b0};
                quo_q <= {quo_q[24:0], rem_ge};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: hand-computed quotients, latency, handshake and reset behaviour.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = 32'h0;
    logic [31:0] divisor = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] out;
`ifdef FP_DIV_FLAGS_EN
    logic [4:0]  flags;
`endif

    int total = 0;
    int bad = 0;

    fp_div_seq dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .out(out)
`ifdef FP_DIV_FLAGS_EN
        ,
        .flags(flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle (or in its done cycle).
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input logic [4:0] exp_fl);
        int n;
        n = 0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, n, 32'd28);
        check({tag, " out"}, out, exp_out);
        check({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
`ifdef FP_DIV_FLAGS_EN
        check({tag, " flags"}, {27'd0, flags}, {27'd0, exp_fl});
`else
        if (exp_fl == 5'b11111) $display("note: unexpected flag vector for %s", tag);
`endif
    endtask

    initial begin
        int first_done;
        int dcnt;
        int busy_err;

        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset out", out, 32'h0);
`ifdef FP_DIV_FLAGS_EN
        check("reset flags", {27'd0, flags}, 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("1000/5", 32'h447A0000, 32'h40A00000, 32'h43480000, 5'b00000);
        @(posedge clk);
        #1;
        run_op("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001);
        run_op("6/3 back2back", 32'h40C00000, 32'h40400000, 32'h40000000, 5'b00000);
        run_op("-1/0", 32'hBF800000, 32'h00000000, 32'hFF800000, 5'b01000);
        run_op("0/-0", 32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10000);
        run_op("max/0.5", 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101);
        run_op("min/2", 32'h00800000, 32'h40000000, 32'h00000000, 5'b00011);
        run_op("nan/1", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00000);
        run_op("inf/2", 32'h7F800000, 32'h40000000, 32'h7F800000, 5'b00000);
        run_op("sub/-1", 32'h00400000, 32'hBF800000, 32'h80000000, 5'b00000);

        // start pulsed at edge 10 while busy must be ignored
        @(posedge clk);
        #1;
        dividend = 32'h447A0000;
        divisor  = 32'h40A00000;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        first_done = -1;
        dcnt = 0;
        busy_err = 0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 10) begin
                dividend = 32'h40C00000;
                divisor  = 32'h40400000;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                dcnt++;
                if (first_done < 0) first_done = n;
            end
            if (n < 28 && !busy) busy_err++;
            if (n >= 28 && busy) busy_err++;
        end
        check("ignored_start first_done", first_done, 32'd28);
        check("ignored_start done_count", dcnt, 32'd1);
        check("ignored_start busy_shape", busy_err, 32'd0);
        check("ignored_start out", out, 32'h43480000);

        // asynchronous reset mid-DIVIDE
        dividend = 32'h3F800000;
        divisor  = 32'h40400000;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 15; n++) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst done", {31'd0, done}, 32'd0);
        check("midrst out", out, 32'h0);
`ifdef FP_DIV_FLAGS_EN
        check("midrst flags", {27'd0, flags}, 32'd0);
`endif
        #2;
        rst = 1'b0;
        dcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("midrst no_done", dcnt, 32'd0);
        check("midrst idle", {31'd0, busy}, 32'd0);
        run_op("after_rst 6/3", 32'h40C00000, 32'h40400000, 32'h40000000, 5'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
